// File: rtl/pimt_operand_align.sv
// pimt_operand_align
//   Matches alpha, phi and powsub4 operands arriving on three independent
//   valid-only streams and releases them as one set for the pimt2 multiply
//   pair. alpha_r/phi_r leave together, one cycle after the set is matched.
//   powsub4 leaves MUL_LAT cycles later, so it lines up with the first
//   multiplier's result.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   alpha_in / alpha_in_vld    alpha operand stream
//   phi_in   / phi_in_vld      phi operand stream
//   pow_in   / pow_in_vld      powsub4 operand stream
//   alpha_r, phi_r, *_vld      matched operands to multiplier 1 (vld is a pulse)
//   powsub4, powsub4_vld       delayed operand to multiplier 2
//   ovf[2:0]                   sticky drop flags {pow, phi, alpha}
module pimt_operand_align #(
  parameter int unsigned DW      = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MUL_LAT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] alpha_in,
  input  logic          alpha_in_vld,
  input  logic [DW-1:0] phi_in,
  input  logic          phi_in_vld,
  input  logic [DW-1:0] pow_in,
  input  logic          pow_in_vld,
  output logic [DW-1:0] alpha_r,
  output logic          alpha_r_vld,
  output logic [DW-1:0] phi_r,
  output logic          phi_r_vld,
  output logic [DW-1:0] powsub4,
  output logic          powsub4_vld,
  output logic [2:0]    ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Stream index: 0 = alpha, 1 = phi, 2 = pow
  logic [2:0]    in_vld;
  logic [DW-1:0] in_data [3];
  logic [DW-1:0] head    [3];
  logic [2:0]    nonempty;
  logic [2:0]    drop;
  logic          fire;

  assign in_vld     = {pow_in_vld, phi_in_vld, alpha_in_vld};
  assign in_data[0] = alpha_in;
  assign in_data[1] = phi_in;
  assign in_data[2] = pow_in;

  // Fire only looks at registered counts, so a push into an empty FIFO
  // becomes poppable on the following cycle.
  assign fire = &nonempty;

  for (genvar s = 0; s < 3; s++) begin : g_fifo
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full;
    logic          push;

    assign full = (cnt_q == CW'(DEPTH));
    // A full FIFO still accepts when it is popped in the same cycle.
    assign push = in_vld[s] && (!full || fire);
    assign drop[s] = in_vld[s] && full && !fire;

    always_comb begin
      cnt_d = cnt_q;
      if (push && !fire) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!push && fire) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push) wr_q <= wr_q + PW'(1);
        if (fire) rd_q <= rd_q + PW'(1);
      end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= in_data[s];
    end

    assign head[s]     = mem_q[rd_q];
    assign nonempty[s] = (cnt_q != '0);
  end

  logic [DW-1:0] alpha_q;
  logic [DW-1:0] phi_q;
  logic          vld_q;
  logic [DW-1:0] sh_dat_q [MUL_LAT];
  logic [MUL_LAT-1:0] sh_vld_q;
  logic [DW-1:0] pow_q;
  logic          pow_vld_q;
  logic [2:0]    ovf_q;

  // sh_*_q[0] is loaded on the same edge as alpha_r; the final output
  // register adds the last stage so powsub4_vld trails alpha_r_vld by MUL_LAT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alpha_q   <= '0;
      phi_q     <= '0;
      vld_q     <= 1'b0;
      sh_vld_q  <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) sh_dat_q[i] <= '0;
      pow_q     <= '0;
      pow_vld_q <= 1'b0;
      ovf_q     <= '0;
    end else begin
      vld_q <= fire;
      if (fire) begin
        alpha_q <= head[0];
        phi_q   <= head[1];
      end
      sh_vld_q[0] <= fire;
      sh_dat_q[0] <= head[2];
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        sh_vld_q[i] <= sh_vld_q[i-1];
        sh_dat_q[i] <= sh_dat_q[i-1];
      end
      pow_vld_q <= sh_vld_q[MUL_LAT-1];
      if (sh_vld_q[MUL_LAT-1]) pow_q <= sh_dat_q[MUL_LAT-1];
      ovf_q <= ovf_q | drop;
    end
  end

  assign alpha_r     = alpha_q;
  assign phi_r       = phi_q;
  assign alpha_r_vld = vld_q;
  assign phi_r_vld   = vld_q;
  assign powsub4     = pow_q;
  assign powsub4_vld = pow_vld_q;
  assign ovf         = ovf_q;

endmodule
